// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types and helpers for the hazard/forwarding controller.
//  - reg_num_t      : architectural register number (5 bits)
//  - fwd_sel_t      : E-stage operand mux select
//  - e_rec_t        : destination/source record of the instruction in E
//  - mw_rec_t       : destination record of the instructions in M and W
//  - fwd_select()   : forward-select decision for one E-stage operand
package hazard_fwd_ctrl_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_num_t;
  typedef logic [1:0]       fwd_sel_t;

  localparam fwd_sel_t FWD_NORMAL = 2'b00;
  localparam fwd_sel_t FWD_W2E    = 2'b01;
  localparam fwd_sel_t FWD_M2E    = 2'b10;

  // Only the fields the controller actually consumes downstream are kept.
  typedef struct packed {
    reg_num_t rs;
    reg_num_t rt;
    logic     rs_use;
    logic     rt_use;
    reg_num_t wr;
    logic     regwr;
    logic     load;
  } e_rec_t;

  typedef struct packed {
    reg_num_t wr;
    logic     regwr;
  } mw_rec_t;

  // M has the newer value, so it wins over W. $0 is hardwired, never forwarded.
  function automatic fwd_sel_t fwd_select(input reg_num_t src,
                                          input logic     src_use,
                                          input mw_rec_t  m,
                                          input mw_rec_t  w);
    fwd_sel_t sel;
    sel = FWD_NORMAL;
    if (src_use && (src != '0)) begin
      if (m.regwr && (m.wr == src))
        sel = FWD_M2E;
      else if (w.regwr && (w.wr == src))
        sel = FWD_W2E;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_md_busy.sv
// Mult/div busy counter.
//  clk, rst_n : clock, async active-low reset
//  load       : an md instruction enters E this edge; counter reloads MD_LAT
//  busy       : HI/LO not yet valid (counter nonzero)
// Otherwise the counter decrements and saturates at zero.
module hazard_fwd_ctrl_md_busy #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= CNT_W'(MD_LAT);
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard / forwarding controller for a 5-stage pipeline.
//  Inputs : decode-stage fields (rsD, rtD, rs_useD, rt_useD, wr_regD, reg_wrD,
//           mem_to_regD, md_startD, hilo_rdD) and branch squash flush_brD.
//  Outputs: forwardalu_A/B  E-stage operand selects (normal / W->E / M->E)
//           stallF, stallD  hold PC and IF/ID register
//           flushE          bubble into ID/EX register
//           md_busy         HI/LO still being produced by mult/div
//  Keeps private E/M/W destination records that shadow the datapath pipeline.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
#(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       rs_useD,
  input  logic       rt_useD,
  input  logic [4:0] wr_regD,
  input  logic       reg_wrD,
  input  logic       mem_to_regD,
  input  logic       md_startD,
  input  logic       hilo_rdD,
  input  logic       flush_brD,
  output logic [1:0] forwardalu_A,
  output logic [1:0] forwardalu_B,
  output logic       stallF,
  output logic       stallD,
  output logic       flushE,
  output logic       md_busy
);

  e_rec_t  e_rec_p0;
  mw_rec_t m_rec_p1;
  mw_rec_t w_rec_p2;

  logic load_use;
  logic md_interlock;
  logic stall;
  logic md_adv;
  logic busy;

  // Load in E whose result a D-stage source needs: one bubble lets it reach M.
  assign load_use = e_rec_p0.load && e_rec_p0.regwr && (e_rec_p0.wr != '0) &&
                    ((rs_useD && (rsD == e_rec_p0.wr)) ||
                     (rt_useD && (rtD == e_rec_p0.wr)));

  assign md_interlock = (hilo_rdD || md_startD) && busy;
  assign stall        = load_use || md_interlock;

  // Counter only restarts when the md instruction really advances into E.
  assign md_adv = md_startD && !stall && !flush_brD;

  // D -> E -> M -> W record pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_rec_p0 <= '0;
      m_rec_p1 <= '0;
      w_rec_p2 <= '0;
    end else begin
      w_rec_p2 <= m_rec_p1;
      m_rec_p1 <= '{wr: e_rec_p0.wr, regwr: e_rec_p0.regwr};
      if (stall || flush_brD)
        e_rec_p0 <= '0;
      else
        e_rec_p0 <= '{rs: rsD, rt: rtD, rs_use: rs_useD, rt_use: rt_useD,
                      wr: wr_regD, regwr: reg_wrD, load: mem_to_regD};
    end
  end

  hazard_fwd_ctrl_md_busy #(
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) u_md_busy (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (md_adv),
    .busy  (busy)
  );

  assign forwardalu_A = fwd_select(e_rec_p0.rs, e_rec_p0.rs_use, m_rec_p1, w_rec_p2);
  assign forwardalu_B = fwd_select(e_rec_p0.rt, e_rec_p0.rt_use, m_rec_p1, w_rec_p2);

  // Stall wins for F/D even when a branch squashes the D instruction.
  assign stallF  = stall;
  assign stallD  = stall;
  assign flushE  = stall;
  assign md_busy = busy;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;

  localparam int MD_LAT = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rsD, rtD, wr_regD;
  logic       rs_useD, rt_useD, reg_wrD, mem_to_regD, md_startD, hilo_rdD, flush_brD;
  logic [1:0] forwardalu_A, forwardalu_B;
  logic       stallF, stallD, flushE, md_busy;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.MD_LAT(MD_LAT), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .rsD(rsD), .rtD(rtD), .rs_useD(rs_useD), .rt_useD(rt_useD),
    .wr_regD(wr_regD), .reg_wrD(reg_wrD), .mem_to_regD(mem_to_regD),
    .md_startD(md_startD), .hilo_rdD(hilo_rdD), .flush_brD(flush_brD),
    .forwardalu_A(forwardalu_A), .forwardalu_B(forwardalu_B),
    .stallF(stallF), .stallD(stallD), .flushE(flushE), .md_busy(md_busy)
  );

  typedef struct {
    logic [4:0] rs, rt, wr;
    logic rs_use, rt_use, regwr, load, md, hilo, flush;
  } ins_t;

  // Reference model: last three instructions issued into E, plus the cycle
  // number from which HI/LO becomes valid.
  ins_t d_cur, pe, pm, pw, nop_i;
  int   cyc, ready_cyc;
  int   n_assert, n_fail;

  function automatic ins_t mk(logic [4:0] rs, logic [4:0] rt, logic ru, logic tu,
                              logic [4:0] wr, logic rw, logic ld, logic md,
                              logic hl, logic fl);
    ins_t i;
    i.rs = rs; i.rt = rt; i.rs_use = ru; i.rt_use = tu; i.wr = wr;
    i.regwr = rw; i.load = ld; i.md = md; i.hilo = hl; i.flush = fl;
    return i;
  endfunction

  function automatic logic [1:0] exp_fwd(logic [4:0] x, logic u);
    if (!u || x == 5'd0) return 2'b00;
    if (pm.regwr && pm.wr == x) return 2'b10;
    if (pw.regwr && pw.wr == x) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_busy();
    return cyc < ready_cyc;
  endfunction

  function automatic logic exp_stall();
    logic lu;
    lu = pe.load && pe.regwr && pe.wr != 5'd0 &&
         ((d_cur.rs_use && d_cur.rs == pe.wr) || (d_cur.rt_use && d_cur.rt == pe.wr));
    return lu || ((d_cur.hilo || d_cur.md) && exp_busy());
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_fa"},     {30'd0, forwardalu_A}, {30'd0, exp_fwd(pe.rs, pe.rs_use)});
    chk({tag, "_fb"},     {30'd0, forwardalu_B}, {30'd0, exp_fwd(pe.rt, pe.rt_use)});
    chk({tag, "_stallF"}, {31'd0, stallF},  {31'd0, exp_stall()});
    chk({tag, "_stallD"}, {31'd0, stallD},  {31'd0, exp_stall()});
    chk({tag, "_flushE"}, {31'd0, flushE},  {31'd0, exp_stall()});
    chk({tag, "_busy"},   {31'd0, md_busy}, {31'd0, exp_busy()});
  endtask

  // Drive D-stage fields shortly after a rising edge and check before the next.
  task automatic apply(input ins_t i, input string tag);
    d_cur = i;
    rsD = i.rs; rtD = i.rt; rs_useD = i.rs_use; rt_useD = i.rt_use;
    wr_regD = i.wr; reg_wrD = i.regwr; mem_to_regD = i.load;
    md_startD = i.md; hilo_rdD = i.hilo; flush_brD = i.flush;
    #3;
    chk_model(tag);
  endtask

  task automatic tick();
    logic s;
    s = exp_stall();
    @(posedge clk);
    if (d_cur.md && !s && !d_cur.flush) ready_cyc = cyc + 1 + MD_LAT;
    pw = pm;
    pm = pe;
    pe = (s || d_cur.flush) ? nop_i : d_cur;
    cyc++;
    #1;
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    pe = nop_i; pm = nop_i; pw = nop_i; ready_cyc = 0;
    chk({tag, "_stall"}, {31'd0, stallF}, 32'd0);
    chk({tag, "_busy"},  {31'd0, md_busy}, 32'd0);
    chk({tag, "_fa"},    {30'd0, forwardalu_A}, 32'd0);
    chk({tag, "_fb"},    {30'd0, forwardalu_B}, 32'd0);
    rst_n = 1'b1;
    #1;
  endtask

  ins_t add3, sub_a, sub_b, lw2, add_lu, add_lu_fl, or8, mult_i, mflo_i, r_i;
  logic last_stall;

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0; ready_cyc = 0;
    nop_i = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pe = nop_i; pm = nop_i; pw = nop_i; d_cur = nop_i;
    rst_n = 1'b0;
    rsD = 0; rtD = 0; rs_useD = 0; rt_useD = 0; wr_regD = 0; reg_wrD = 0;
    mem_to_regD = 0; md_startD = 0; hilo_rdD = 0; flush_brD = 0;
    #12;
    chk("rst_fa",    {30'd0, forwardalu_A}, 32'd0);
    chk("rst_fb",    {30'd0, forwardalu_B}, 32'd0);
    chk("rst_stall", {29'd0, stallF, stallD, flushE}, 32'd0);
    chk("rst_busy",  {31'd0, md_busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // add $3,$1,$2 ; sub $4,$3,$5  -> A from M
    add3  = mk(1, 2, 1, 1, 3, 1, 0, 0, 0, 0);
    sub_a = mk(3, 5, 1, 1, 4, 1, 0, 0, 0, 0);
    sub_b = mk(5, 3, 1, 1, 4, 1, 0, 0, 0, 0);
    apply(add3, "t2a"); tick();
    apply(sub_a, "t2a"); tick();
    apply(nop_i, "t2a_e");
    chk("t2_fa_m2e", {30'd0, forwardalu_A}, 32'd2);
    tick();
    // one nop between -> A from W
    apply(add3, "t2b"); tick();
    apply(nop_i, "t2b"); tick();
    apply(sub_a, "t2b"); tick();
    apply(nop_i, "t2b_e");
    chk("t2_fa_w2e", {30'd0, forwardalu_A}, 32'd1);
    tick();
    // rt path on B
    apply(add3, "t2c"); tick();
    apply(sub_b, "t2c"); tick();
    apply(nop_i, "t2c_e");
    chk("t2_fb_m2e", {30'd0, forwardalu_B}, 32'd2);
    chk("t2_fa_none", {30'd0, forwardalu_A}, 32'd0);
    tick();
    apply(add3, "t2d"); tick();
    apply(nop_i, "t2d"); tick();
    apply(sub_b, "t2d"); tick();
    apply(nop_i, "t2d_e");
    chk("t2_fb_w2e", {30'd0, forwardalu_B}, 32'd1);
    tick();

    // M and W both write $3 -> M priority; writes to $0 never forward
    apply(add3, "t3a"); tick();
    apply(add3, "t3a"); tick();
    apply(mk(3, 3, 1, 1, 5, 1, 0, 0, 0, 0), "t3a"); tick();
    apply(nop_i, "t3a_e");
    chk("t3_fa_prio", {30'd0, forwardalu_A}, 32'd2);
    chk("t3_fb_prio", {30'd0, forwardalu_B}, 32'd2);
    tick();
    apply(mk(1, 2, 1, 1, 0, 1, 0, 0, 0, 0), "t3b"); tick();
    apply(mk(0, 0, 1, 1, 6, 1, 0, 0, 0, 0), "t3b"); tick();
    apply(nop_i, "t3b_e");
    chk("t3_fa_r0", {30'd0, forwardalu_A}, 32'd0);
    chk("t3_fb_r0", {30'd0, forwardalu_B}, 32'd0);
    tick();

    // lw $2,0($1) ; add $4,$2,$2 -> one stall, then W->E on both
    lw2    = mk(1, 0, 1, 0, 2, 1, 1, 0, 0, 0);
    add_lu = mk(2, 2, 1, 1, 4, 1, 0, 0, 0, 0);
    apply(lw2, "t4"); tick();
    apply(add_lu, "t4_s");
    chk("t4_stallF", {31'd0, stallF}, 32'd1);
    chk("t4_flushE", {31'd0, flushE}, 32'd1);
    tick();
    apply(add_lu, "t4_r");
    chk("t4_release", {31'd0, stallD}, 32'd0);
    tick();
    apply(nop_i, "t4_e");
    chk("t4_fa", {30'd0, forwardalu_A}, 32'd1);
    chk("t4_fb", {30'd0, forwardalu_B}, 32'd1);
    tick();

    // mult then mflo: 32 stall cycles
    mult_i = mk(8, 9, 1, 1, 0, 0, 0, 1, 0, 0);
    mflo_i = mk(0, 0, 0, 0, 10, 1, 0, 0, 1, 0);
    apply(mult_i, "t5"); tick();
    for (int k = 0; k < MD_LAT; k++) begin
      apply(mflo_i, "t5_w");
      chk("t5_stall_on", {31'd0, stallF}, 32'd1);
      tick();
    end
    apply(mflo_i, "t5_go");
    chk("t5_stall_off", {31'd0, stallF}, 32'd0);
    chk("t5_busy_off", {31'd0, md_busy}, 32'd0);
    tick();
    // second mult while busy stalls; reset mid-stall clears everything
    apply(mult_i, "t5b"); tick();
    apply(mult_i, "t5b_s");
    chk("t5_mult2_stall", {31'd0, stallD}, 32'd1);
    tick();
    apply(mult_i, "t5b_s2"); tick();
    reset_pulse("t1_mid");
    apply(mult_i, "t1_after");
    chk("t1_no_resid", {31'd0, stallF}, 32'd0);
    tick();
    reset_pulse("t1_mult");

    // flush during load-use stall: bubble into E, squashed add never forwards
    add_lu_fl = mk(2, 2, 1, 1, 4, 1, 0, 0, 0, 1);
    or8       = mk(4, 4, 1, 1, 8, 1, 0, 0, 0, 0);
    apply(lw2, "t6"); tick();
    apply(add_lu_fl, "t6_s");
    chk("t6_stall_hold", {31'd0, stallF}, 32'd1);
    tick();
    apply(or8, "t6"); tick();
    apply(nop_i, "t6_e");
    chk("t6_fa_squash", {30'd0, forwardalu_A}, 32'd0);
    chk("t6_fb_squash", {30'd0, forwardalu_B}, 32'd0);
    tick();

    // randomized traffic against the model
    last_stall = 1'b0;
    r_i = nop_i;
    for (int n = 0; n < 400; n++) begin
      int kind;
      if (!last_stall) begin
        kind = $urandom_range(0, 99);
        if (kind < 4)
          r_i = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1, 1, 0, 0, 0, 1, 0, 0);
        else if (kind < 10)
          r_i = mk(0, 0, 0, 0, 5'($urandom_range(0, 3)), 1, 0, 0, 1, 0);
        else if (kind < 35)
          r_i = mk(5'($urandom_range(0, 3)), 0, 1, 0, 5'($urandom_range(0, 3)), 1, 1, 0, 0, 0);
        else
          r_i = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, 0, 0, 0);
      end
      r_i.flush = ($urandom_range(0, 9) == 0);
      apply(r_i, "rnd");
      last_stall = exp_stall();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
